// File: rtl/i2c_burst_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_burst_master : single-master I2C engine issuing one multi-byte
//                    read or write burst per start request (open-drain pins).
// Revision: 1.0
// ---------------------------------------------------------------------------
module i2c_burst_master #(
  parameter int QTR_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       addr,
  input  logic             rw,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wdata,
  output logic             wdata_req,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_oe,
  output logic             sda_oe
);

  localparam int               CNT_W   = (QTR_DIV > 2) ? $clog2(QTR_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QTR_DIV - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_WRITE    = 4'd4;
  localparam logic [3:0] S_WACK     = 4'd5;
  localparam logic [3:0] S_READ     = 4'd6;
  localparam logic [3:0] S_RACK     = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       qtr;
  logic [1:0]       qtr_last;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [7:0]       wbuf;
  logic [LEN_W-1:0] byte_cnt;
  logic             rw_q;
  logic             accept;
  logic             stretch;
  logic             tick;
  logic             phase_end;
  logic             last_bit;
  logic             last_byte;

  assign accept    = (state == S_IDLE) && start;
  // A released SCL that still reads low means the slave is stretching.
  assign stretch   = busy && !scl_oe && !scl_i;
  assign tick      = busy && !stretch && (tick_cnt == CNT_MAX);
  assign qtr_last  = (state == S_START) ? 2'd1 : (state == S_STOP) ? 2'd2 : 2'd3;
  assign phase_end = tick && (qtr == qtr_last);
  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == '0);
  assign wdata_req = (state == S_WACK) && phase_end && !sda_i && !last_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_START;
      S_START:    if (phase_end) state_nxt = S_ADDR;
      S_ADDR:     if (phase_end && last_bit) state_nxt = S_ADDR_ACK;
      S_ADDR_ACK: if (phase_end) state_nxt = sda_i ? S_STOP : (rw_q ? S_READ : S_WRITE);
      S_WRITE:    if (phase_end && last_bit) state_nxt = S_WACK;
      S_WACK:     if (phase_end) state_nxt = (sda_i || last_byte) ? S_STOP : S_WRITE;
      S_READ:     if (phase_end && last_bit) state_nxt = S_RACK;
      S_RACK:     if (phase_end) state_nxt = last_byte ? S_STOP : S_READ;
      S_STOP:     if (phase_end) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      S_START: sda_oe = (qtr == 2'd1);
      S_ADDR, S_WRITE: begin
        scl_oe = !qtr[1];
        sda_oe = !shreg[7];
      end
      S_ADDR_ACK, S_WACK, S_READ: scl_oe = !qtr[1];
      S_RACK: begin
        scl_oe = !qtr[1];
        sda_oe = !last_byte;
      end
      S_STOP: begin
        scl_oe = (qtr == 2'd0);
        sda_oe = (qtr != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      qtr         <= 2'd0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'd0;
      wbuf        <= 8'd0;
      byte_cnt    <= '0;
      rw_q        <= 1'b0;
      nack        <= 1'b0;
      rdata       <= 8'd0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      if (accept) begin
        tick_cnt <= '0;
        qtr      <= 2'd0;
        bit_cnt  <= 3'd0;
        shreg    <= {addr, rw};
        wbuf     <= wdata;
        byte_cnt <= len;
        rw_q     <= rw;
        nack     <= 1'b0;
      end else if (busy && !stretch) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          qtr <= phase_end ? 2'd0 : qtr + 2'd1;
        end
        if (phase_end) begin
          case (state)
            S_ADDR, S_WRITE: begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
            S_ADDR_ACK: begin
              if (sda_i) nack <= 1'b1;
              else       shreg <= wbuf;
            end
            S_WACK: begin
              if (sda_i) begin
                nack <= 1'b1;
              end else if (!last_byte) begin
                shreg    <= wdata;
                byte_cnt <= byte_cnt - 1'b1;
              end
            end
            S_READ: begin
              shreg   <= {shreg[6:0], sda_i};
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                rdata       <= {shreg[6:0], sda_i};
                rdata_valid <= 1'b1;
              end
            end
            S_RACK: if (!last_byte) byte_cnt <= byte_cnt - 1'b1;
            S_STOP: done <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
